// File: rtl/knn_topk_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knn_topk_vote_pkg
// Brief    : Shared KNN definitions: FSM state encoding, default sizes,
//            vote-count width helper.
// Revision : 1.0 - initial release
// ============================================================================
package knn_topk_vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_DONE    = 2'd3
    } knn_state_t;

    localparam int KNN_K_DEF       = 4;
    localparam int KNN_DIST_W_DEF  = 32;
    localparam int KNN_LABEL_W_DEF = 8;

    // Width able to hold any count 0..k
    function automatic int knn_cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/knn_vote_count.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote_count
// Brief    : Combinational count of valid slots whose label matches label_ref.
// Revision : 1.0 - initial release
// ============================================================================
module knn_vote_count
    import knn_topk_vote_pkg::*;
#(
    parameter int K       = KNN_K_DEF,
    parameter int LABEL_W = KNN_LABEL_W_DEF
) (
    input  logic [K-1:0][LABEL_W-1:0] labels,
    input  logic [K-1:0]              valid,
    input  logic [LABEL_W-1:0]        label_ref,
    output logic [$clog2(K+1)-1:0]    count
);

    localparam int CNT_W = knn_cnt_w(K);

    always_comb begin
        count = '0;
        for (int i = 0; i < K; i++) begin
            if (valid[i] && (labels[i] == label_ref)) begin
                count = count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/knn_topk_vote.sv
`default_nettype none
// ============================================================================
// Module   : knn_topk_vote
// Brief    : Keeps the K nearest (distance, label) results in a sorted list,
//            then majority-votes their labels. Optional macro
//            KNN_TOPK_NEAREST_OUT_EN exports the nearest neighbour.
// Revision : 1.0 - initial release
// ============================================================================
module knn_topk_vote
    import knn_topk_vote_pkg::*;
#(
    parameter int K       = KNN_K_DEF,
    parameter int DIST_W  = KNN_DIST_W_DEF,
    parameter int LABEL_W = KNN_LABEL_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIST_W-1:0]        dist_in,
    input  logic [LABEL_W-1:0]       label_in,
    input  logic                     in_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [LABEL_W-1:0]       res_label,
    output logic [$clog2(K+1)-1:0]   res_votes,
`ifdef KNN_TOPK_NEAREST_OUT_EN
    output logic [DIST_W-1:0]        res_min_dist,
    output logic [LABEL_W-1:0]       res_min_label,
`endif
    output logic                     busy
);

    localparam int                CNT_W  = knn_cnt_w(K);
    localparam int                IDX_W  = $clog2(K);
    localparam logic [IDX_W-1:0]  LAST_J = IDX_W'(K - 1);

    knn_state_t                  r_state;
    knn_state_t                  w_state_nxt;

    logic [K-1:0][DIST_W-1:0]    r_dist;
    logic [K-1:0][LABEL_W-1:0]   r_label;
    logic [K-1:0]                r_v;
    logic [K-1:0][DIST_W-1:0]    w_dist_nxt;
    logic [K-1:0][LABEL_W-1:0]   w_label_nxt;
    logic [K-1:0]                w_v_nxt;
    logic [K-1:0]                w_lt;
    logic                        w_accept;

    logic [IDX_W-1:0]            r_j;
    logic [LABEL_W-1:0]          r_best_label;
    logic [CNT_W-1:0]            r_best_cnt;
    logic [CNT_W-1:0]            w_cnt;
    logic                        w_take;
    logic [LABEL_W-1:0]          w_fin_label;
    logic [CNT_W-1:0]            w_fin_cnt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_COLLECT;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_IDLE;
                ST_COLLECT: if (in_valid && in_last) w_state_nxt = ST_VOTE;
                ST_VOTE:    if (r_j == LAST_J)       w_state_nxt = ST_DONE;
                ST_DONE:    if (res_ready)           w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_COLLECT);
    assign res_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = in_ready && in_valid && !start;

    // ------------------------------------------------------------------
    // Sorted insertion list
    // ------------------------------------------------------------------
    // Valid slots are packed low and sorted ascending, so w_lt is a
    // thermometer: w_lt[i-1] set means the insert point is at or below i-1.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign w_lt[i] = !r_v[i] || (dist_in < r_dist[i]);
        if (i == 0) begin : g_head
            assign w_dist_nxt[i]  = w_lt[i] ? dist_in  : r_dist[i];
            assign w_label_nxt[i] = w_lt[i] ? label_in : r_label[i];
            assign w_v_nxt[i]     = w_lt[i] | r_v[i];
        end else begin : g_tail
            assign w_dist_nxt[i]  = w_lt[i-1] ? r_dist[i-1]  : (w_lt[i] ? dist_in  : r_dist[i]);
            assign w_label_nxt[i] = w_lt[i-1] ? r_label[i-1] : (w_lt[i] ? label_in : r_label[i]);
            assign w_v_nxt[i]     = w_lt[i-1] ? r_v[i-1]     : (w_lt[i] | r_v[i]);
        end
    end

    // ------------------------------------------------------------------
    // Vote
    // ------------------------------------------------------------------
    knn_vote_count #(
        .K       (K),
        .LABEL_W (LABEL_W)
    ) u_vote_count (
        .labels    (r_label),
        .valid     (r_v),
        .label_ref (r_label[r_j]),
        .count     (w_cnt)
    );

    // Strict compare keeps the nearer neighbour on ties
    assign w_take      = r_v[r_j] && (w_cnt > r_best_cnt);
    assign w_fin_label = w_take ? r_label[r_j] : r_best_label;
    assign w_fin_cnt   = w_take ? w_cnt        : r_best_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dist        <= '0;
            r_label       <= '0;
            r_v           <= '0;
            r_j           <= '0;
            r_best_label  <= '0;
            r_best_cnt    <= '0;
            res_label     <= '0;
            res_votes     <= '0;
`ifdef KNN_TOPK_NEAREST_OUT_EN
            res_min_dist  <= '0;
            res_min_label <= '0;
`endif
        end else if (start) begin
            r_v <= '0;
        end else begin
            if (w_accept) begin
                r_dist       <= w_dist_nxt;
                r_label      <= w_label_nxt;
                r_v          <= w_v_nxt;
                r_j          <= '0;
                r_best_label <= '0;
                r_best_cnt   <= '0;
            end
            if (r_state == ST_VOTE) begin
                r_j          <= r_j + 1'b1;
                r_best_label <= w_fin_label;
                r_best_cnt   <= w_fin_cnt;
                if (r_j == LAST_J) begin
                    res_label     <= w_fin_label;
                    res_votes     <= w_fin_cnt;
`ifdef KNN_TOPK_NEAREST_OUT_EN
                    res_min_dist  <= r_dist[0];
                    res_min_label <= r_label[0];
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_topk_vote.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_knn_topk_vote
// Brief    : Directed table-driven bench for knn_topk_vote (K=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_knn_topk_vote;

    localparam int K       = 4;
    localparam int DIST_W  = 32;
    localparam int LABEL_W = 8;
    localparam int CNT_W   = $clog2(K + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [DIST_W-1:0]    dist_in;
    logic [LABEL_W-1:0]   label_in;
    logic                 in_last;
    logic                 res_valid;
    logic                 res_ready;
    logic [LABEL_W-1:0]   res_label;
    logic [CNT_W-1:0]     res_votes;
    logic                 busy;
`ifdef KNN_TOPK_NEAREST_OUT_EN
    logic [DIST_W-1:0]    res_min_dist;
    logic [LABEL_W-1:0]   res_min_label;
`endif

    always #5 clk = ~clk;

    knn_topk_vote #(
        .K       (K),
        .DIST_W  (DIST_W),
        .LABEL_W (LABEL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dist_in       (dist_in),
        .label_in      (label_in),
        .in_last       (in_last),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_label     (res_label),
        .res_votes     (res_votes),
`ifdef KNN_TOPK_NEAREST_OUT_EN
        .res_min_dist  (res_min_dist),
        .res_min_label (res_min_label),
`endif
        .busy          (busy)
    );

    typedef struct {
        int           n;
        logic [31:0]  d [6];
        logic [7:0]   l [6];
        logic [7:0]   exp_label;
        int           exp_votes;
        logic [31:0]  exp_min_d;
        logic [7:0]   exp_min_l;
    } vec_t;

    vec_t vecs [7];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // All tasks are entered and left right after a negedge
    task automatic beat(input logic [31:0] d, input logic [7:0] l, input logic last);
        in_valid = 1'b1;
        dist_in  = d;
        label_in = l;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp_l, input int exp_v);
        int lat;
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, K + 1);
        chk({tag, " res_label"}, res_label, exp_l);
        chk({tag, " res_votes"}, res_votes, exp_v);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " res_valid drop"}, res_valid, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic run_vec(input int t);
        string tag;
        tag = $sformatf("v%0d", t);
        pulse_start();
        for (int b = 0; b < vecs[t].n; b++) begin
            beat(vecs[t].d[b], vecs[t].l[b], b == vecs[t].n - 1);
        end
        wait_result(tag, vecs[t].exp_label, vecs[t].exp_votes);
`ifdef KNN_TOPK_NEAREST_OUT_EN
        chk({tag, " min_dist"}, res_min_dist, vecs[t].exp_min_d);
        chk({tag, " min_label"}, res_min_label, vecs[t].exp_min_l);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_label"}, res_label, 0);
        chk({tag, " res_votes"}, res_votes, 0);
        chk({tag, " busy"}, busy, 0);
`ifdef KNN_TOPK_NEAREST_OUT_EN
        chk({tag, " min_dist"}, res_min_dist, 0);
        chk({tag, " min_label"}, res_min_label, 0);
`endif
    endtask

    initial begin
        int ok;

        vecs[0].n = 5; vecs[0].d = '{50, 10, 30, 20, 40, 0}; vecs[0].l = '{1, 2, 1, 2, 3, 0};
        vecs[0].exp_label = 2; vecs[0].exp_votes = 2; vecs[0].exp_min_d = 10; vecs[0].exp_min_l = 2;
        vecs[1].n = 4; vecs[1].d = '{5, 6, 7, 8, 0, 0}; vecs[1].l = '{3, 4, 3, 4, 0, 0};
        vecs[1].exp_label = 3; vecs[1].exp_votes = 2; vecs[1].exp_min_d = 5; vecs[1].exp_min_l = 3;
        vecs[2].n = 5; vecs[2].d = '{9, 9, 9, 9, 9, 0}; vecs[2].l = '{1, 2, 3, 4, 5, 0};
        vecs[2].exp_label = 1; vecs[2].exp_votes = 1; vecs[2].exp_min_d = 9; vecs[2].exp_min_l = 1;
        vecs[3].n = 1; vecs[3].d = '{7, 0, 0, 0, 0, 0}; vecs[3].l = '{6, 0, 0, 0, 0, 0};
        vecs[3].exp_label = 6; vecs[3].exp_votes = 1; vecs[3].exp_min_d = 7; vecs[3].exp_min_l = 6;
        vecs[4].n = 4; vecs[4].d = '{100, 3, 3, 200, 0, 0}; vecs[4].l = '{7, 8, 9, 7, 0, 0};
        vecs[4].exp_label = 7; vecs[4].exp_votes = 2; vecs[4].exp_min_d = 3; vecs[4].exp_min_l = 8;
        vecs[5].n = 4; vecs[5].d = '{32'hFFFF_FFFF, 32'h8000_0000, 1, 2, 0, 0}; vecs[5].l = '{5, 5, 6, 6, 0, 0};
        vecs[5].exp_label = 6; vecs[5].exp_votes = 2; vecs[5].exp_min_d = 1; vecs[5].exp_min_l = 6;
        vecs[6].n = 6; vecs[6].d = '{40, 30, 20, 10, 5, 50}; vecs[6].l = '{1, 1, 2, 2, 3, 1};
        vecs[6].exp_label = 2; vecs[6].exp_votes = 2; vecs[6].exp_min_d = 5; vecs[6].exp_min_l = 3;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        res_ready = 1'b0; dist_in = '0; label_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // in_valid while IDLE must not move the FSM
        beat(3, 4, 1'b1);
        chk("idle ignore busy", busy, 0);
        chk("idle ignore in_ready", in_ready, 0);

        for (int t = 0; t < 7; t++) begin
            run_vec(t);
            handshake($sformatf("v%0d", t));
        end

        // Result held while res_ready low; in_valid ignored in DONE
        run_vec(0);
        in_valid = 1'b1; in_last = 1'b1; dist_in = 1; label_in = 9;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (!(res_valid === 1'b1 && res_label === 8'd2 && res_votes === 3'd2 && in_ready === 1'b0))
                ok = 0;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("hold stable", ok, 1);
        handshake("hold");
        chk("hold keeps label", res_label, 2);
        chk("hold keeps votes", res_votes, 2);

        // Reset in the middle of VOTE
        pulse_start();
        beat(50, 1, 1'b0);
        beat(60, 1, 1'b1);
        @(negedge clk);
        chk("mid vote busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid reset");
        rst = 1'b1;
        @(negedge clk);

        // start in COLLECT clears the list and wins over a same-cycle beat
        pulse_start();
        beat(1, 9, 1'b0);
        beat(2, 9, 1'b0);
        in_valid = 1'b1; dist_in = 0; label_in = 7; in_last = 1'b1;
        pulse_start();
        in_valid = 1'b0; in_last = 1'b0;
        chk("restart in_ready", in_ready, 1);
        beat(4, 3, 1'b0);
        beat(5, 4, 1'b1);
        wait_result("restart", 3, 1);
        handshake("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
